mccpu_ctrl: RTL

MCCPU_CTRL -- requirements
Module: mccpu_ctrl

---
 rtl/mccpu_ctrl_pkg.sv | 45 ++++
 rtl/mccpu_ctrl_aludec.sv | 38 +++
 rtl/mccpu_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mccpu_ctrl_pkg.sv
// rtl/mccpu_ctrl_pkg.sv - ALU codes, opcode/funct constants and state encodings for the multicycle controller
// HALT exists only when CTRL_ILLEGAL_EN is defined.
package mccpu_ctrl_pkg;

   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD  = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;

   typedef enum logic [3:0] {
      ST_FETCH, ST_DCODE, ST_MA, ST_MR, ST_MW, ST_MWB, ST_EXE, ST_AWB, ST_BR, ST_JMP
`ifdef CTRL_ILLEGAL_EN
      , ST_HALT
`endif
   } state_t;

endpackage

// File: rtl/mccpu_ctrl_aludec.sv
// rtl/mccpu_ctrl_aludec.sv - combinational ALU operation / A-source decode for the EXE state
// ALUOp of ALU_NOP marks an opcode/funct pair that has no EXE behaviour.
module mccpu_aludec
   import mccpu_ctrl_pkg::*;
(
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   output logic [3:0] ALUOp,
   output logic [1:0] ALUSrcA
);

   always_comb begin
      ALUOp   = ALU_NOP;
      ALUSrcA = 2'd1;
      case (Op)
         OP_RTYPE: begin
            case (Funct)
               FN_ADD:  ALUOp = ALU_ADD;
               FN_SUB:  ALUOp = ALU_SUB;
               FN_AND:  ALUOp = ALU_AND;
               FN_OR:   ALUOp = ALU_OR;
               FN_NOR:  ALUOp = ALU_NOR;
               FN_SLT:  ALUOp = ALU_SLT;
               FN_SLTU: ALUOp = ALU_SLTU;
               FN_SLL:  begin ALUOp = ALU_SLL; ALUSrcA = 2'd2; end
               FN_SRL:  begin ALUOp = ALU_SRL; ALUSrcA = 2'd2; end
               default: ALUOp = ALU_NOP;
            endcase
         end
         OP_ADDI: ALUOp = ALU_ADD;
         OP_ORI:  ALUOp = ALU_OR;
         OP_SLTI: ALUOp = ALU_SLT;
         OP_LUI:  ALUOp = ALU_LUI;
         default: ALUOp = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/mccpu_ctrl.sv
// rtl/mccpu_ctrl.sv - Moore FSM controller for the multicycle MIPS-subset CPU
// Optional CTRL_ILLEGAL_EN adds the Illegal output and a HALT state for undecodable instructions.
module mccpu_ctrl
   import mccpu_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
`ifdef CTRL_ILLEGAL_EN
   output logic       Illegal,
`endif
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] WDSel,
   output logic       EXTOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUOp,
   output logic [1:0] PCSource
);

`ifdef CTRL_ILLEGAL_EN
   localparam state_t ST_BAD = ST_HALT;
`else
   localparam state_t ST_BAD = ST_FETCH;
`endif

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic [5:0] funct_q, funct_d;
   logic [5:0] dec_op, dec_funct;
   logic [3:0] dec_alu_op;
   logic [1:0] dec_alu_src_a;
   logic       unused_zero;

   // Branch resolution happens in the datapath; the controller never looks at Zero.
   assign unused_zero = Zero;

   // DCODE decodes the live IR fields; later states use the copy captured at DCODE.
   assign dec_op    = (state_q == ST_DCODE) ? Op    : op_q;
   assign dec_funct = (state_q == ST_DCODE) ? Funct : funct_q;

   mccpu_aludec u_aludec (
      .Op      (dec_op),
      .Funct   (dec_funct),
      .ALUOp   (dec_alu_op),
      .ALUSrcA (dec_alu_src_a)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         op_q    <= 6'd0;
         funct_q <= 6'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         funct_q <= funct_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      funct_d     = funct_q;
`ifdef CTRL_ILLEGAL_EN
      Illegal     = 1'b0;
`endif
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'd0;
      WDSel       = 2'd0;
      EXTOp       = 1'b0;
      ALUSrcA     = 2'd0;
      ALUSrcB     = 2'd0;
      ALUOp       = ALU_NOP;
      PCSource    = 2'd0;
      case (state_q)
         ST_FETCH: begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'd1;
            ALUOp   = ALU_ADD;
            state_d = ST_DCODE;
         end
         ST_DCODE: begin
            ALUSrcB = 2'd3;
            ALUOp   = ALU_ADD;
            EXTOp   = 1'b1;
            op_d    = Op;
            funct_d = Funct;
            case (Op)
               OP_LW, OP_SW: state_d = ST_MA;
               OP_RTYPE, OP_ADDI, OP_ORI, OP_SLTI, OP_LUI:
                  state_d = (dec_alu_op != ALU_NOP) ? ST_EXE : ST_BAD;
               OP_BEQ:       state_d = ST_BR;
               OP_J, OP_JAL: state_d = ST_JMP;
               default:      state_d = ST_BAD;
            endcase
         end
         ST_MA: begin
            ALUSrcA = 2'd1;
            ALUSrcB = 2'd2;
            ALUOp   = ALU_ADD;
            EXTOp   = 1'b1;
            state_d = (op_q == OP_SW) ? ST_MW : ST_MR;
         end
         ST_MR: begin
            IorD    = 1'b1;
            state_d = ST_MWB;
         end
         ST_MWB: begin
            RegWrite = 1'b1;
            WDSel    = 2'd1;
            state_d  = ST_FETCH;
         end
         ST_MW: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_EXE: begin
            ALUOp   = dec_alu_op;
            ALUSrcA = dec_alu_src_a;
            ALUSrcB = (op_q == OP_RTYPE) ? 2'd0 : 2'd2;
            EXTOp   = (op_q == OP_ADDI) || (op_q == OP_SLTI);
            state_d = ST_AWB;
         end
         ST_AWB: begin
            RegWrite = 1'b1;
            RegDst   = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
            state_d  = ST_FETCH;
         end
         ST_BR: begin
            ALUSrcA     = 2'd1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'd1;
            state_d     = ST_FETCH;
         end
         ST_JMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'd2;
            if (op_q == OP_JAL) begin
               RegWrite = 1'b1;
               RegDst   = 2'd2;
               WDSel    = 2'd2;
            end
            state_d = ST_FETCH;
         end
`ifdef CTRL_ILLEGAL_EN
         ST_HALT: begin
            Illegal = 1'b1;
            state_d = ST_HALT;
         end
`endif
         default: state_d = ST_FETCH;
      endcase
      // Nothing may be written while reset is held, whatever state we are leaving.
      if (rst) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
      end
   end

endmodule
